// File: rtl/pcs_tx_oset_ctrl_if.sv
// pcs_tx_oset_ctrl_if: GMII transmit inputs and encoder-side ordered-set outputs of the PCS TX controller
interface pcs_tx_oset_ctrl_if;
    logic [2:0] xmit;
    logic [7:0] TXD;
    logic       TX_EN;
    logic       TX_ER;
    logic       receiving;
    logic [2:0] tx_o_set;
    logic [7:0] tx_data;
    logic       tx_even;
    logic       transmitting;
    logic       COL;
    modport master (
        output xmit, TXD, TX_EN, TX_ER, receiving,
        input  tx_o_set, tx_data, tx_even, transmitting, COL
    );
    modport slave (
        input  xmit, TXD, TX_EN, TX_ER, receiving,
        output tx_o_set, tx_data, tx_even, transmitting, COL
    );
endinterface

// File: rtl/pcs_tx_oset_ctrl.sv
// pcs_tx_oset_ctrl: 1000BASE-X PCS transmit ordered-set selector; frames GMII data into /S/ /D/ /T/ /R/
// sequences, keeps /I/ and /C/ pairs aligned to even code-group positions and aborts frames on xmit changes.
module pcs_tx_oset_ctrl (
    input logic               GTX_CLK,
    input logic               mr_main_reset,
    pcs_tx_oset_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        TX_TEST_XMIT, XMIT_DATA, TX_DATA, END_T, EXTEND, EPD2, EPD3, ABORT_ALIGN
    } state_t;

    localparam logic [2:0] OS_I = 3'd0, OS_S = 3'd1, OS_D = 3'd2, OS_T = 3'd3,
                           OS_R = 3'd4, OS_V = 3'd5, OS_C = 3'd6;

    state_t     state_q, state_d;
    logic [2:0] oset_q, oset_d;
    logic [7:0] data_q, data_d;
    logic       even_q, trans_q, trans_d;
    logic       is_data, pos_even, ext_ok;
    logic [2:0] idle_os;

    assign is_data  = bus.xmit == 3'b010;
    assign pos_even = ~even_q;  // the code-group produced at this edge lands on an even position
    assign ext_ok   = bus.TX_ER && bus.TXD == 8'h0F;
    assign idle_os  = bus.xmit == 3'b100 ? OS_C : OS_I;

    always_comb begin
        state_d = state_q;
        oset_d  = OS_I;
        trans_d = 1'b0;
        case (state_q)
            TX_TEST_XMIT: begin
                oset_d = pos_even ? idle_os : oset_q;
                if (is_data && !bus.TX_EN && !bus.TX_ER && pos_even) state_d = XMIT_DATA;
            end
            XMIT_DATA: begin
                if (pos_even && !is_data) begin
                    oset_d  = idle_os;
                    state_d = TX_TEST_XMIT;
                end else if (pos_even && bus.TX_EN && !bus.TX_ER) begin
                    oset_d  = OS_S;
                    trans_d = 1'b1;
                    state_d = TX_DATA;
                end
            end
            TX_DATA: begin
                trans_d = 1'b1;
                oset_d  = !bus.TX_EN ? OS_T : bus.TX_ER ? OS_V : OS_D;
                if (!bus.TX_EN) state_d = END_T;
            end
            END_T: begin
                oset_d  = OS_R;
                state_d = ext_ok ? EXTEND : EPD2;
            end
            EXTEND: begin
                oset_d = bus.TX_ER && !ext_ok ? OS_V : OS_R;
                if (!bus.TX_ER) state_d = EPD2;
            end
            EPD2: begin
                oset_d  = OS_R;
                state_d = pos_even ? EPD3 : XMIT_DATA;
            end
            EPD3: begin
                oset_d  = OS_R;
                state_d = XMIT_DATA;
            end
            ABORT_ALIGN: begin
                oset_d  = idle_os;
                state_d = TX_TEST_XMIT;
            end
            default: state_d = TX_TEST_XMIT;
        endcase
        if (!is_data && state_q inside {TX_DATA, END_T, EXTEND, EPD2, EPD3}) begin
            trans_d = 1'b0;
            oset_d  = pos_even ? idle_os : OS_V;
            state_d = pos_even ? TX_TEST_XMIT : ABORT_ALIGN;
        end
        data_d = oset_d == OS_D ? bus.TXD : 8'h00;
    end

    always_ff @(posedge GTX_CLK) begin
        if (mr_main_reset) begin
            state_q <= TX_TEST_XMIT;
            oset_q  <= OS_I;
            data_q  <= 8'h00;
            even_q  <= 1'b1;
            trans_q <= 1'b0;
        end else begin
            state_q <= state_d;
            oset_q  <= oset_d;
            data_q  <= data_d;
            even_q  <= ~even_q;
            trans_q <= trans_d;
        end
    end

    assign bus.tx_o_set     = oset_q;
    assign bus.tx_data      = data_q;
    assign bus.tx_even      = even_q;
    assign bus.transmitting = trans_q;
    assign bus.COL          = trans_q & bus.receiving;
endmodule

// File: tb/tb_pcs_tx_oset_ctrl.sv
// tb_pcs_tx_oset_ctrl: directed and randomized GMII stimulus checked against a phase/counter model of the
// ordered-set stream, plus literal expectations for the reset, basic frame, abort and mid-frame reset cases.
module tb_pcs_tx_oset_ctrl;
    logic clk = 1'b0;
    logic rst;
    pcs_tx_oset_ctrl_if bus ();
    pcs_tx_oset_ctrl dut (.GTX_CLK(clk), .mr_main_reset(rst), .bus(bus.slave));
    always #5 clk = ~clk;

    localparam int I = 0, S = 1, D = 2, T = 3, R = 4, V = 5, C = 6;
    int npass = 0, ntot = 0;
    int ph, pair, r_left;
    bit ext, m_even;
    int nx_o, nx_d;
    bit nx_t;
    int ex_o, ex_d;
    bit ex_t, ex_e;
    bit valid = 1'b0;
    int lit_o = -1, lit_d = -1, lit_e = -1, lit_t = -1;

    task automatic chk(input string nm, input int act, input int req);
        ntot++;
        if (act == req) npass++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, req, $time);
    endtask

    // ph: 0 outside data mode, 1 idle in data mode, 2 in frame, 3 trailing /R/s, 4 /V/ sent, alignment pending
    task automatic model(input logic [2:0] x, input logic en, input logic er, input logic [7:0] d, input logic rs);
        bit ev, isdata;
        int sel, o;
        bit t;
        if (rs) begin
            ph = 0; pair = I; m_even = 1'b1; nx_o = I; nx_d = 0; nx_t = 1'b0;
            return;
        end
        ev = !m_even;
        isdata = x == 3'b010;
        sel = x == 3'b100 ? C : I;
        o = I;
        t = 1'b0;
        if ((ph == 2 || ph == 3) && !isdata) begin
            o = ev ? sel : V;
            if (ev) pair = sel;
            ph = ev ? 0 : 4;
        end else if (ph == 4) begin
            o = sel; pair = sel; ph = 0;
        end else if (ph == 0 || (ph == 1 && ev && !isdata)) begin
            if (ev) pair = sel;
            o = pair;
            ph = (isdata && !en && !er && ev) ? 1 : 0;
        end else if (ph == 1) begin
            if (ev && en && !er) begin o = S; t = 1'b1; ph = 2; end
        end else if (ph == 2) begin
            t = 1'b1;
            if (en) o = er ? V : D;
            else begin o = T; ph = 3; r_left = 2; ext = 1'b0; end
        end else begin
            o = R;
            if (ext) begin
                if (er) o = (d == 8'h0F) ? R : V;
                else ext = 1'b0;
            end else begin
                r_left--;
                if (r_left == 1 && er && d == 8'h0F) ext = 1'b1;
                if (r_left == 0) begin
                    if (ev) r_left = 1;
                    else ph = 1;
                end
            end
        end
        nx_o = o;
        nx_d = o == D ? int'(d) : 0;
        nx_t = t;
        m_even = ev;
    endtask

    task automatic cyc(input logic [2:0] x, input logic en, input logic er, input logic [7:0] d,
                       input logic rx, input logic rs, input int lo, input int ld, input int le, input int lt);
        bus.xmit = x; bus.TX_EN = en; bus.TX_ER = er; bus.TXD = d; bus.receiving = rx; rst = rs;
        model(x, en, er, d, rs);
        @(posedge clk);
        #1;
        ex_o = nx_o; ex_d = nx_d; ex_t = nx_t; ex_e = m_even; valid = 1'b1;
        lit_o = lo; lit_d = ld; lit_e = le; lit_t = lt;
    endtask

    always @(negedge clk) begin
        if (valid) begin
            chk("tx_o_set", int'(bus.tx_o_set), ex_o);
            chk("tx_data", int'(bus.tx_data), ex_d);
            chk("tx_even", int'(bus.tx_even), int'(ex_e));
            chk("transmitting", int'(bus.transmitting), int'(ex_t));
            chk("COL", int'(bus.COL), int'(ex_t & bus.receiving));
            if (lit_o >= 0) chk("literal tx_o_set", int'(bus.tx_o_set), lit_o);
            if (lit_d >= 0) chk("literal tx_data", int'(bus.tx_data), lit_d);
            if (lit_e >= 0) chk("literal tx_even", int'(bus.tx_even), lit_e);
            if (lit_t >= 0) chk("literal transmitting", int'(bus.transmitting), lit_t);
        end
    end

    logic [7:0] fd [12] = '{8'h55, 8'h55, 8'hD5, 8'h01, 8'h02, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    int fo [12] = '{S, D, D, D, D, D, T, R, R, R, I, I};
    int fdat [12] = '{0, 'h55, 'hD5, 1, 2, 3, 0, 0, 0, 0, 0, 0};
    int ao [6] = '{S, D, D, V, I, I};

    initial begin
        logic [2:0] xr;
        logic enr, rxr;
        xr = 3'b010; enr = 1'b0; rxr = 1'b0;
        cyc(3'b001, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, I, 0, 1, 0);
        cyc(3'b001, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, I, 0, 1, 0);
        for (int i = 0; i < 4; i++) cyc(3'b001, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, I, 0, int'(i % 2 == 1), 0);
        for (int i = 0; i < 5; i++) cyc(3'b010, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, I, 0, int'(i % 2 == 1), 0);
        for (int i = 0; i < 12; i++)
            cyc(3'b010, i < 6, 1'b0, fd[i], 1'b1, 1'b0, fo[i], fdat[i], int'(i % 2 == 0), int'(i < 7));
        for (int i = 0; i < 6; i++)
            cyc(i < 3 ? 3'b010 : 3'b001, 1'b1, 1'b0, 8'h77, 1'b1, 1'b0, ao[i], ao[i] == D ? 'h77 : 0,
                int'(i % 2 == 0), int'(i < 3));
        cyc(3'b010, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, I, 0, 1, 0);
        cyc(3'b010, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, I, 0, 0, 0);
        cyc(3'b010, 1'b1, 1'b0, 8'hA1, 1'b0, 1'b0, S, 0, 1, 1);
        cyc(3'b010, 1'b1, 1'b0, 8'hB2, 1'b0, 1'b0, D, 'hB2, 0, 1);
        cyc(3'b010, 1'b1, 1'b0, 8'hC3, 1'b1, 1'b1, I, 0, 1, 0);
        cyc(3'b001, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, I, 0, 0, 0);
        for (int i = 0; i < 6000; i++) begin
            logic er, rs;
            logic [7:0] d;
            if ($urandom_range(0, 99) < 2) begin
                int r = $urandom_range(0, 99);
                xr = r < 70 ? 3'b010 : r < 82 ? 3'b001 : r < 94 ? 3'b100 : 3'($urandom_range(0, 7));
            end
            if ($urandom_range(0, 9) == 0) enr = ~enr;
            if ($urandom_range(0, 7) == 0) rxr = ~rxr;
            er = enr ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 3) == 0);
            d = (er && $urandom_range(0, 1) == 1) ? 8'h0F : 8'($urandom_range(0, 255));
            rs = $urandom_range(0, 399) == 0;
            cyc(xr, enr, er, d, rxr, rs, -1, -1, -1, -1);
        end
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
